// File: rtl/nios_timer_sw_agent_mc.sv
//------------------------------------------------------------------------------
// nios_timer_sw_agent_mc
//   Multi-channel machine-timer / software-interrupt agent for Nios V.
//   One shared 64-bit mtime, advanced by a programmable prescaler. CH_NUM
//   mtimecmp/msip channels drive per-channel timer and software IRQs.
//
// Parameters
//   CH_NUM      number of channels (1..15)
//   ADDR_W      Avalon word-address width (4+4*CH_NUM <= 2**ADDR_W)
//   PRESCALE_W  prescaler divisor width (1..16)
//
// Ports
//   clk                           system clock
//   reset_reset                   asynchronous active-high reset
//   timer_sw_agent_write          write strobe
//   timer_sw_agent_writedata      write data (32)
//   timer_sw_agent_byteenable     write byte lanes (4)
//   timer_sw_agent_address        word address (ADDR_W)
//   timer_sw_agent_read           read strobe
//   timer_sw_agent_readdata       read data, valid with readdatavalid, else 0
//   timer_sw_agent_readdatavalid  one-cycle read response pulse
//   timer_irq                     per-channel mtime >= mtimecmp (registered)
//   sw_irq                        per-channel msip bit
//
// Word map
//   0 MTIME_LO, 1 MTIME_HI, 2 CTRL (bit0 EN, DIV at bit 8 up), 3 reserved
//   4+4c CMP_LO, 5+4c CMP_HI, 6+4c MSIP (bit0), 7+4c reserved
//
// Build option
//   TIMER_SNAPSHOT_EN : a read of MTIME_LO latches mtime[63:32] into a shadow
//                       that MTIME_HI reads return, making LO-then-HI reads
//                       atomic. Undefined: MTIME_HI reads the live value.
//------------------------------------------------------------------------------
module nios_timer_sw_agent_mc #(
   parameter int CH_NUM     = 2,
   parameter int ADDR_W     = 6,
   parameter int PRESCALE_W = 8
) (
   input  logic              clk,
   input  logic              reset_reset,
   input  logic              timer_sw_agent_write,
   input  logic [31:0]       timer_sw_agent_writedata,
   input  logic [3:0]        timer_sw_agent_byteenable,
   input  logic [ADDR_W-1:0] timer_sw_agent_address,
   input  logic              timer_sw_agent_read,
   output logic [31:0]       timer_sw_agent_readdata,
   output logic              timer_sw_agent_readdatavalid,
   output logic [CH_NUM-1:0] timer_irq,
   output logic [CH_NUM-1:0] sw_irq
);

   // Byte-lane merge of a 32-bit register with write data.
   function automatic logic [31:0] merge32(input logic [31:0] old_v,
                                           input logic [31:0] wd,
                                           input logic [3:0]  be);
      logic [31:0] r;
      for (int b = 0; b < 4; b++)
         r[8*b +: 8] = be[b] ? wd[8*b +: 8] : old_v[8*b +: 8];
      return r;
   endfunction

   logic [63:0]           mtime;
   logic                  en;
   logic [PRESCALE_W-1:0] div;
   logic [PRESCALE_W-1:0] cnt;
   logic [63:0]           cmp [CH_NUM];
   logic [CH_NUM-1:0]     msip;
   logic [31:0]           rdata_p1;
   logic                  vld_p1;
`ifdef TIMER_SNAPSHOT_EN
   logic [31:0]           mtime_hi_shadow;
`endif

   logic                  wr_act;
   logic                  sel_mt_lo, sel_mt_hi, sel_ctrl;
   logic [CH_NUM-1:0]     sel_cmp_lo, sel_cmp_hi, sel_msip;
   logic                  tick;
   logic [63:0]           mtime_nxt;
   logic                  en_new;
   logic [PRESCALE_W-1:0] div_new;
   logic [31:0]           ctrl_rd;
   logic [31:0]           mtime_hi_rd;
   logic [31:0]           rd_mux;

   // A write with no byte lanes enabled is treated as no write at all.
   assign wr_act    = timer_sw_agent_write && (timer_sw_agent_byteenable != 4'b0000);
   assign sel_mt_lo = (timer_sw_agent_address == ADDR_W'(0));
   assign sel_mt_hi = (timer_sw_agent_address == ADDR_W'(1));
   assign sel_ctrl  = (timer_sw_agent_address == ADDR_W'(2));
   assign tick      = en && (cnt == div);

   always_comb begin
      for (int c = 0; c < CH_NUM; c++) begin
         sel_cmp_lo[c] = (timer_sw_agent_address == ADDR_W'(4 + 4*c));
         sel_cmp_hi[c] = (timer_sw_agent_address == ADDR_W'(5 + 4*c));
         sel_msip[c]   = (timer_sw_agent_address == ADDR_W'(6 + 4*c));
      end
   end

   // CTRL fields updated lane by lane; DIV starts at bit 8.
   always_comb begin
      en_new = timer_sw_agent_byteenable[0] ? timer_sw_agent_writedata[0] : en;
      for (int i = 0; i < PRESCALE_W; i++)
         div_new[i] = timer_sw_agent_byteenable[(8+i)/8] ? timer_sw_agent_writedata[8+i] : div[i];
   end

   // A software write to either half overrides the tick for that cycle; the
   // other half keeps its pre-edge value, so no carry crosses the halves.
   always_comb begin
      mtime_nxt = tick ? mtime + 64'd1 : mtime;
      if (wr_act && sel_mt_lo)
         mtime_nxt = {mtime[63:32],
                      merge32(mtime[31:0], timer_sw_agent_writedata, timer_sw_agent_byteenable)};
      if (wr_act && sel_mt_hi)
         mtime_nxt = {merge32(mtime[63:32], timer_sw_agent_writedata, timer_sw_agent_byteenable),
                      mtime[31:0]};
   end

   always_comb begin
      ctrl_rd                     = '0;
      ctrl_rd[0]                  = en;
      ctrl_rd[8 +: PRESCALE_W]    = div;
   end

`ifdef TIMER_SNAPSHOT_EN
   assign mtime_hi_rd = mtime_hi_shadow;
`else
   assign mtime_hi_rd = mtime[63:32];
`endif

   // Read data reflects pre-edge state; unmapped words read as zero.
   always_comb begin
      rd_mux = '0;
      if (sel_mt_lo) rd_mux = mtime[31:0];
      if (sel_mt_hi) rd_mux = mtime_hi_rd;
      if (sel_ctrl)  rd_mux = ctrl_rd;
      for (int c = 0; c < CH_NUM; c++) begin
         if (sel_cmp_lo[c]) rd_mux = cmp[c][31:0];
         if (sel_cmp_hi[c]) rd_mux = cmp[c][63:32];
         if (sel_msip[c])   rd_mux = {31'd0, msip[c]};
      end
   end

   always_ff @(posedge clk or posedge reset_reset) begin
      if (reset_reset) begin
         mtime     <= '0;
         en        <= 1'b1;
         div       <= '0;
         cnt       <= '0;
         for (int c = 0; c < CH_NUM; c++)
            cmp[c] <= 64'hFFFF_FFFF_FFFF_FFFF;
         msip      <= '0;
         timer_irq <= '0;
         rdata_p1  <= '0;
         vld_p1    <= 1'b0;
`ifdef TIMER_SNAPSHOT_EN
         mtime_hi_shadow <= '0;
`endif
      end else begin
         if (en)
            cnt <= (cnt == div) ? '0 : cnt + PRESCALE_W'(1);
         if (wr_act && sel_ctrl) begin
            en  <= en_new;
            div <= div_new;
            cnt <= '0;
         end
         mtime <= mtime_nxt;
         for (int c = 0; c < CH_NUM; c++) begin
            if (wr_act && sel_cmp_lo[c])
               cmp[c][31:0]  <= merge32(cmp[c][31:0], timer_sw_agent_writedata,
                                        timer_sw_agent_byteenable);
            if (wr_act && sel_cmp_hi[c])
               cmp[c][63:32] <= merge32(cmp[c][63:32], timer_sw_agent_writedata,
                                        timer_sw_agent_byteenable);
            if (wr_act && sel_msip[c] && timer_sw_agent_byteenable[0])
               msip[c] <= timer_sw_agent_writedata[0];
            // Compares current registers, so the IRQ lags the update by one cycle.
            timer_irq[c] <= (mtime >= cmp[c]);
         end
         // ---- read response stage p1 ----
         vld_p1   <= timer_sw_agent_read;
         rdata_p1 <= timer_sw_agent_read ? rd_mux : 32'd0;
`ifdef TIMER_SNAPSHOT_EN
         if (timer_sw_agent_read && sel_mt_lo)
            mtime_hi_shadow <= mtime[63:32];
`endif
      end
   end

   assign timer_sw_agent_readdata      = rdata_p1;
   assign timer_sw_agent_readdatavalid = vld_p1;
   assign sw_irq                       = msip;

endmodule
